// File: rtl/pot_source_arbiter.sv
// pot_source_arbiter: picks the analog stick or mouse-emulated pots and fire bits for controller port 1.
// Latency: one cycle from any input (or accumulator update) to every output.
// Backpressure: none; inputs are sampled every cycle and mouse packets are detected on strobe toggles.
module pot_source_arbiter #(
  parameter int STEP_MAX    = 10,
  parameter int HOLDOFF_CYC = 1024,
  parameter bit INVERT_Y    = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] JOYA_IN,
  input  logic [15:0] JOY_IN,
  input  logic [24:0] PS2_MOUSE,
  input  logic        CPU_HALT,
  output logic [7:0]  JOYX_OUT,
  output logic [7:0]  JOYY_OUT,
  output logic [15:0] JOY_OUT,
  output logic        MOUSE_ACTIVE,
  output logic [1:0]  SRC_STATE
);

  typedef enum logic [1:0] {
    ST_JOY   = 2'd0,
    ST_MOUSE = 2'd1,
    ST_LOCK  = 2'd2
  } state_e;

  localparam int CNT_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYC - 1);
  localparam logic signed [8:0] STEP_POS = 9'(STEP_MAX);
  localparam logic signed [8:0] STEP_NEG = 9'(-STEP_MAX);

  state_e            state_q, state_d;
  logic signed [7:0] acc_x_q, acc_x_d;
  logic signed [7:0] acc_y_q, acc_y_d;
  logic              old_stb_q;
  logic              primed_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        joyx_q, joyx_d;
  logic [7:0]        joyy_q, joyy_d;
  logic [15:0]       joy_q, joy_d;
  logic              mouse_q;
  logic [1:0]        src_q;

  logic              toggle;
  logic              ana_active;
  logic              ana_absent;
  logic signed [8:0] dx_raw, dy_raw, dy_dir;
  logic signed [8:0] dx, dy;
  logic              unused_bits;

  // Limit one packet's movement to +/-STEP_MAX.
  function automatic logic signed [8:0] clamp_step(input logic signed [8:0] d);
    logic signed [8:0] r;
    r = d;
    if (d > STEP_POS) begin
      r = STEP_POS;
    end else if (d < STEP_NEG) begin
      r = STEP_NEG;
    end
    return r;
  endfunction

  // Add a delta to a pot position, saturating at the two's complement rails.
  function automatic logic signed [7:0] sat_add(input logic signed [7:0] a,
                                                input logic signed [8:0] d);
    logic signed [9:0] n;
    logic signed [7:0] r;
    n = $signed({{2{a[7]}}, a}) + $signed({d[8], d});
    if (n > 10'sd127) begin
      r = 8'h7F;
    end else if (n < -10'sd128) begin
      r = 8'h80;
    end else begin
      r = n[7:0];
    end
    return r;
  endfunction

  // Low bits of the movement bytes and the overflow flags carry no position information.
  assign unused_bits = ^{PS2_MOUSE[7:6], PS2_MOUSE[3:2], PS2_MOUSE[8], PS2_MOUSE[16]};

  assign toggle     = primed_q && (PS2_MOUSE[24] != old_stb_q);
  assign ana_active = |JOYA_IN;
  assign ana_absent = &JOYA_IN;

  // Mouse bytes are halved and sign-extended to 9 bits before clamping.
  assign dx_raw = {PS2_MOUSE[4], PS2_MOUSE[4], PS2_MOUSE[15:9]};
  assign dy_raw = {PS2_MOUSE[5], PS2_MOUSE[5], PS2_MOUSE[23:17]};
  assign dy_dir = INVERT_Y ? -dy_raw : dy_raw;
  assign dx     = clamp_step(dx_raw);
  assign dy     = clamp_step(dy_dir);

  // Source selection: halt beats analog stick beats mouse packet.
  always_comb begin
    state_d = state_q;
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    unique case (state_q)
      ST_JOY: begin
        if (CPU_HALT) begin
          state_d = ST_LOCK;
        end else if (toggle && !ana_active) begin
          state_d = ST_MOUSE;
          acc_x_d = sat_add(8'sd0, dx);
          acc_y_d = sat_add(8'sd0, dy);
        end
      end
      ST_MOUSE: begin
        if (CPU_HALT) begin
          state_d = ST_LOCK;
          acc_x_d = 8'sd0;
          acc_y_d = 8'sd0;
        end else if (ana_active) begin
          state_d = ST_JOY;
          acc_x_d = 8'sd0;
          acc_y_d = 8'sd0;
        end else if (toggle) begin
          acc_x_d = sat_add(acc_x_q, dx);
          acc_y_d = sat_add(acc_y_q, dy);
        end
      end
      ST_LOCK: begin
        acc_x_d = 8'sd0;
        acc_y_d = 8'sd0;
        if (!CPU_HALT && (cnt_q == '0)) begin
          state_d = ST_JOY;
        end
      end
      default: begin
        state_d = ST_JOY;
        acc_x_d = 8'sd0;
        acc_y_d = 8'sd0;
      end
    endcase
  end

  // Holdoff counter: reloaded whenever halted, so even a one-cycle halt gets the full quiet period.
  always_comb begin
    cnt_d = cnt_q;
    if (CPU_HALT) begin
      cnt_d = HOLD_LOAD;
    end else if ((state_q == ST_LOCK) && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Output values follow the next state so pots, fire bits and state flags line up.
  always_comb begin
    joyx_d = JOYA_IN[7:0];
    joyy_d = JOYA_IN[15:8];
    if (state_d == ST_MOUSE) begin
      joyx_d = acc_x_d;
      joyy_d = acc_y_d;
    end
    joy_d = {JOY_IN[15:6],
             (state_d == ST_MOUSE) ? PS2_MOUSE[1:0] : JOY_IN[5:4],
             JOY_IN[3:0] & {4{~ana_absent}}};
  end

  // All state and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_JOY;
      acc_x_q   <= 8'sd0;
      acc_y_q   <= 8'sd0;
      old_stb_q <= 1'b0;
      primed_q  <= 1'b0;
      cnt_q     <= '0;
      joyx_q    <= 8'h00;
      joyy_q    <= 8'h00;
      joy_q     <= 16'h0000;
      mouse_q   <= 1'b0;
      src_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      acc_x_q   <= acc_x_d;
      acc_y_q   <= acc_y_d;
      old_stb_q <= PS2_MOUSE[24];
      primed_q  <= 1'b1;
      cnt_q     <= cnt_d;
      joyx_q    <= joyx_d;
      joyy_q    <= joyy_d;
      joy_q     <= joy_d;
      mouse_q   <= (state_d == ST_MOUSE);
      src_q     <= state_d;
    end
  end

  assign JOYX_OUT     = joyx_q;
  assign JOYY_OUT     = joyy_q;
  assign JOY_OUT      = joy_q;
  assign MOUSE_ACTIVE = mouse_q;
  assign SRC_STATE    = src_q;

endmodule

// File: tb/tb_pot_source_arbiter.sv
// Bench for pot_source_arbiter: directed sequences, a vector table and randomized traffic
// compared cycle by cycle against a behavioural model of the source-selection rules.
module tb_pot_source_arbiter;

  localparam int STEP  = 10;
  localparam int HOLD  = 1024;
  localparam bit INV_Y = 1'b0;

  logic        CLK;
  logic        RESET_N;
  logic [15:0] JOYA_IN;
  logic [15:0] JOY_IN;
  logic [24:0] PS2_MOUSE;
  logic        CPU_HALT;
  logic [7:0]  JOYX_OUT;
  logic [7:0]  JOYY_OUT;
  logic [15:0] JOY_OUT;
  logic        MOUSE_ACTIVE;
  logic [1:0]  SRC_STATE;

  pot_source_arbiter #(
    .STEP_MAX   (STEP),
    .HOLDOFF_CYC(HOLD),
    .INVERT_Y   (INV_Y)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .JOYA_IN     (JOYA_IN),
    .JOY_IN      (JOY_IN),
    .PS2_MOUSE   (PS2_MOUSE),
    .CPU_HALT    (CPU_HALT),
    .JOYX_OUT    (JOYX_OUT),
    .JOYY_OUT    (JOYY_OUT),
    .JOY_OUT     (JOY_OUT),
    .MOUSE_ACTIVE(MOUSE_ACTIVE),
    .SRC_STATE   (SRC_STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  logic stb_v  = 1'b0;

  // Behavioural model state: source as 0/1/2, positions as plain integers,
  // holdoff expressed as count of quiet (un-halted) cycles spent locked out.
  int         m_src, m_ax, m_ay, m_quiet;
  logic       m_old;
  bit         m_primed;
  logic [7:0] e_x, e_y;
  logic [15:0] e_joy;

  typedef struct {
    logic [15:0] joya;
    logic [15:0] joyin;
    logic [7:0]  ex;
    logic [7:0]  ey;
    logic [15:0] ejoy;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Movement byte halved; a set sign bit puts the value 128 lower.
  function automatic int pkt_delta(input logic [7:0] b, input logic s);
    int m;
    m = int'(b[7:1]);
    return s ? m - 128 : m;
  endfunction

  task automatic model_reset();
    m_src = 0; m_ax = 0; m_ay = 0; m_quiet = 0;
    m_old = 1'b0; m_primed = 0;
    e_x = 8'h00; e_y = 8'h00; e_joy = 16'h0000;
  endtask

  task automatic model_tick();
    bit tog;
    int dx, dy, nxt, bx, by;
    tog = m_primed && (PS2_MOUSE[24] != m_old);
    m_old = PS2_MOUSE[24];
    m_primed = 1;
    dx = clampi(pkt_delta(PS2_MOUSE[15:8], PS2_MOUSE[4]), -STEP, STEP);
    dy = pkt_delta(PS2_MOUSE[23:16], PS2_MOUSE[5]);
    if (INV_Y) dy = -dy;
    dy = clampi(dy, -STEP, STEP);
    nxt = m_src;
    if (m_src == 2) begin
      m_ax = 0; m_ay = 0;
      if (CPU_HALT) m_quiet = 0;
      else begin
        m_quiet++;
        if (m_quiet >= HOLD) nxt = 0;
      end
    end else if (CPU_HALT) begin
      nxt = 2; m_ax = 0; m_ay = 0; m_quiet = 0;
    end else if (JOYA_IN != 16'h0000) begin
      nxt = 0; m_ax = 0; m_ay = 0;
    end else if (tog) begin
      bx = (m_src == 1) ? m_ax : 0;
      by = (m_src == 1) ? m_ay : 0;
      nxt = 1;
      m_ax = clampi(bx + dx, -128, 127);
      m_ay = clampi(by + dy, -128, 127);
    end
    m_src = nxt;
    e_x = (nxt == 1) ? 8'(m_ax) : JOYA_IN[7:0];
    e_y = (nxt == 1) ? 8'(m_ay) : JOYA_IN[15:8];
    e_joy = {JOY_IN[15:6], (nxt == 1) ? PS2_MOUSE[1:0] : JOY_IN[5:4],
             (JOYA_IN == 16'hFFFF) ? 4'h0 : JOY_IN[3:0]};
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    @(posedge CLK);
    model_tick();
    #1;
    chk("mdl_joyx", 32'(JOYX_OUT), 32'(e_x));
    chk("mdl_joyy", 32'(JOYY_OUT), 32'(e_y));
    chk("mdl_joy", 32'(JOY_OUT), 32'(e_joy));
    chk("mdl_src", 32'(SRC_STATE), 32'(m_src));
    chk("mdl_mouse", 32'(MOUSE_ACTIVE), 32'(m_src == 1));
  endtask

  task automatic pkt(input logic [7:0] xb, input logic sx, input logic [7:0] yb,
                     input logic sy, input logic [1:0] btn);
    stb_v = ~stb_v;
    PS2_MOUSE = {stb_v, yb, xb, 2'b00, sy, sx, 2'b00, btn};
    step();
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    model_reset();
    #1;
    chk("rst_joyx", 32'(JOYX_OUT), 32'h0);
    chk("rst_joyy", 32'(JOYY_OUT), 32'h0);
    chk("rst_joy", 32'(JOY_OUT), 32'h0);
    chk("rst_src", 32'(SRC_STATE), 32'h0);
    chk("rst_mouse", 32'(MOUSE_ACTIVE), 32'h0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  initial begin
    int bad;
    int halt_left;
    int r;

    tbl[0] = '{16'h2010, 16'h0000, 8'h10, 8'h20, 16'h0000};
    tbl[1] = '{16'hFFFF, 16'h000F, 8'hFF, 8'hFF, 16'h0000};
    tbl[2] = '{16'h0000, 16'h000F, 8'h00, 8'h00, 16'h000F};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 8'hFF, 8'hFF, 16'hFFF0};
    tbl[4] = '{16'h8001, 16'h0035, 8'h01, 8'h80, 16'h0035};
    tbl[5] = '{16'h00FF, 16'h3FC5, 8'hFF, 8'h00, 16'h3FC5};
    tbl[6] = '{16'hFF00, 16'h1234, 8'h00, 8'hFF, 16'h1234};
    tbl[7] = '{16'h7F80, 16'hFFFF, 8'h80, 8'h7F, 16'hFFFF};

    RESET_N   = 1'b1;
    JOYA_IN   = 16'h2010;
    JOY_IN    = 16'h0000;
    PS2_MOUSE = '0;
    CPU_HALT  = 1'b0;
    #2;
    do_reset();

    // Analog stick passes straight through.
    step();
    chk("joy_x", 32'(JOYX_OUT), 32'h10);
    chk("joy_y", 32'(JOYY_OUT), 32'h20);
    chk("joy_src", 32'(SRC_STATE), 32'd0);

    // Mouse entry and accumulation with clamped steps.
    JOYA_IN = 16'h0000;
    pkt(8'h08, 1'b0, 8'h00, 1'b0, 2'b00);
    chk("mouse_enter_src", 32'(SRC_STATE), 32'd1);
    chk("mouse_enter_x", 32'(JOYX_OUT), 32'h04);
    chk("mouse_enter_act", 32'(MOUSE_ACTIVE), 32'd1);
    repeat (6) pkt(8'h7E, 1'b0, 8'h00, 1'b0, 2'b00);
    chk("mouse_acc_x", 32'(JOYX_OUT), 32'h40);

    // Ceiling and floor saturation.
    repeat (8) pkt(8'h7E, 1'b0, 8'h00, 1'b0, 2'b00);
    chk("mouse_sat_hi", 32'(JOYX_OUT), 32'h7F);
    repeat (30) pkt(8'h00, 1'b1, 8'h00, 1'b0, 2'b00);
    chk("mouse_sat_lo", 32'(JOYX_OUT), 32'h80);
    pkt(8'h00, 1'b1, 8'h00, 1'b0, 2'b00);
    chk("mouse_sat_hold", 32'(JOYX_OUT), 32'h80);

    // Buttons in mouse mode, then the stick wins over a same-cycle packet.
    JOY_IN = 16'hC02A;
    pkt(8'h08, 1'b0, 8'h00, 1'b0, 2'b01);
    chk("mouse_btn_x", 32'(JOYX_OUT), 32'h84);
    chk("mouse_btn_joy", 32'(JOY_OUT), 32'hC01A);
    JOYA_IN = 16'h0005;
    pkt(8'h7E, 1'b0, 8'h7E, 1'b0, 2'b01);
    chk("stick_win_src", 32'(SRC_STATE), 32'd0);
    chk("stick_win_x", 32'(JOYX_OUT), 32'h05);
    chk("stick_win_y", 32'(JOYY_OUT), 32'h00);
    chk("stick_win_joy", 32'(JOY_OUT), 32'hC02A);

    // Halt lockout and holdoff.
    JOYA_IN = 16'h0000;
    pkt(8'h08, 1'b0, 8'h00, 1'b0, 2'b00);
    chk("reenter_x", 32'(JOYX_OUT), 32'h04);
    CPU_HALT = 1'b1;
    pkt(8'h7E, 1'b0, 8'h7E, 1'b0, 2'b00);
    chk("halt_src", 32'(SRC_STATE), 32'd2);
    chk("halt_x", 32'(JOYX_OUT), 32'h00);
    chk("halt_act", 32'(MOUSE_ACTIVE), 32'd0);
    repeat (4) pkt(8'h7E, 1'b0, 8'h7E, 1'b0, 2'b00);
    CPU_HALT = 1'b0;
    bad = 0;
    for (int i = 0; i < HOLD - 1; i++) begin
      pkt(8'h7E, 1'b0, 8'h7E, 1'b0, 2'b00);
      if (SRC_STATE != 2'd2) bad++;
    end
    chk("holdoff_hold", 32'(bad), 32'd0);
    pkt(8'h7E, 1'b0, 8'h7E, 1'b0, 2'b00);
    chk("holdoff_exit", 32'(SRC_STATE), 32'd0);
    pkt(8'h08, 1'b0, 8'h00, 1'b0, 2'b00);
    chk("after_hold_src", 32'(SRC_STATE), 32'd1);
    chk("after_hold_x", 32'(JOYX_OUT), 32'h04);

    // Reset mid-accumulate with the strobe already high at release.
    pkt(8'h08, 1'b0, 8'h00, 1'b0, 2'b00);
    #2;
    stb_v = 1'b1;
    PS2_MOUSE = {1'b1, 8'h00, 8'h08, 8'h00};
    do_reset();
    step();
    chk("prime_src", 32'(SRC_STATE), 32'd0);
    chk("prime_x", 32'(JOYX_OUT), 32'h00);
    step();
    chk("prime_src2", 32'(SRC_STATE), 32'd0);
    pkt(8'h08, 1'b0, 8'h00, 1'b0, 2'b00);
    chk("post_rst_src", 32'(SRC_STATE), 32'd1);
    chk("post_rst_x", 32'(JOYX_OUT), 32'h04);

    // Vector table, applied from the stick source.
    JOYA_IN = 16'h2010;
    step();
    for (int i = 0; i < 8; i++) begin
      JOYA_IN = tbl[i].joya;
      JOY_IN  = tbl[i].joyin;
      step();
      chk("tbl_x", 32'(JOYX_OUT), 32'(tbl[i].ex));
      chk("tbl_y", 32'(JOYY_OUT), 32'(tbl[i].ey));
      chk("tbl_joy", 32'(JOY_OUT), 32'(tbl[i].ejoy));
      chk("tbl_src", 32'(SRC_STATE), 32'd0);
    end

    // Randomized traffic against the model.
    JOYA_IN = 16'h0000;
    CPU_HALT = 1'b0;
    do_reset();
    halt_left = 0;
    for (int i = 0; i < 6000; i++) begin
      if (halt_left > 0) begin
        CPU_HALT = 1'b1;
        halt_left--;
      end else begin
        CPU_HALT = 1'b0;
        if ($urandom_range(0, 1499) == 0) halt_left = $urandom_range(1, 6);
      end
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 7) JOYA_IN = 16'h0000;
        else if (r < 8) JOYA_IN = 16'hFFFF;
        else JOYA_IN = 16'($urandom);
      end
      JOY_IN = 16'($urandom);
      if ($urandom_range(0, 1) == 1) stb_v = ~stb_v;
      PS2_MOUSE = {stb_v, 24'($urandom)};
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
